// File: rtl/tl_pkg.sv
// Shared state and lamp codes for the traffic-light controller and its display stage.
package tl_pkg;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } tl_state_e;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;

    // Lamp code for a phase; anything unrecognised shows red so the lamp stays one-hot.
    function automatic logic [2:0] lamp_of(input tl_state_e st);
        logic [2:0] code;
        case (st)
            ST_RED:    code = LIGHT_RED;
            ST_GREEN:  code = LIGHT_GREEN;
            ST_YELLOW: code = LIGHT_YELLOW;
            default:   code = LIGHT_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides fast_clk down to a one-cycle tick every CLK_DIV cycles.
module tick_prescaler #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic fast_clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrapping count of fast_clk cycles within one tick period.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/traffic_light_fsm.sv
// Timed red/green/yellow sequencer with a sticky pedestrian request that
// shortens green to a minimum dwell; all outputs registered.
module traffic_light_fsm
    import tl_pkg::*;
#(
    parameter int CLK_DIV       = 50_000_000,
    parameter int RED_SEC       = 10,
    parameter int GREEN_SEC     = 8,
    parameter int YELLOW_SEC    = 3,
    parameter int MIN_GREEN_SEC = 3
) (
    input  logic       fast_clk,
    input  logic       rst_n,
    input  logic       ped_req,
    output logic [0:2] light,
    output logic [3:0] secs_left,
    output logic       ped_walk
);

    localparam logic [3:0] RED_LOAD    = 4'(RED_SEC - 1);
    localparam logic [3:0] GREEN_LOAD  = 4'(GREEN_SEC - 1);
    localparam logic [3:0] YELLOW_LOAD = 4'(YELLOW_SEC - 1);
    localparam logic [3:0] EARLY_LIM   = 4'(GREEN_SEC - MIN_GREEN_SEC);

    logic       tick_s;
    tl_state_e  state_q, state_d;
    logic [3:0] secs_q, secs_d;
    logic       ped_pending_q, ped_pending_d;
    logic [0:2] light_q, light_d;
    logic       walk_q, walk_d;

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .tick     (tick_s)
    );

    // State, phase counter, request latch and output registers.
    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            state_q       <= ST_RED;
            secs_q        <= RED_LOAD;
            ped_pending_q <= 1'b0;
            light_q       <= LIGHT_RED;
            walk_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            secs_q        <= secs_d;
            ped_pending_q <= ped_pending_d;
            light_q       <= light_d;
            walk_q        <= walk_d;
        end
    end

    // Next phase and countdown; the early green exit uses the request latched before this edge.
    always_comb begin
        state_d       = state_q;
        secs_d        = secs_q;
        ped_pending_d = ped_pending_q;
        if (ped_req && (state_q != ST_RED)) begin
            ped_pending_d = 1'b1;
        end else begin
            ped_pending_d = ped_pending_q;
        end
        case (state_q)
            ST_RED: begin
                if (tick_s && (secs_q == 4'd0)) begin
                    state_d = ST_GREEN;
                    secs_d  = GREEN_LOAD;
                end else if (tick_s) begin
                    secs_d = secs_q - 4'd1;
                end else begin
                    secs_d = secs_q;
                end
            end
            ST_GREEN: begin
                if (tick_s && ((secs_q == 4'd0) || (ped_pending_q && (secs_q <= EARLY_LIM)))) begin
                    state_d = ST_YELLOW;
                    secs_d  = YELLOW_LOAD;
                end else if (tick_s) begin
                    secs_d = secs_q - 4'd1;
                end else begin
                    secs_d = secs_q;
                end
            end
            ST_YELLOW: begin
                if (tick_s && (secs_q == 4'd0)) begin
                    state_d       = ST_RED;
                    secs_d        = RED_LOAD;
                    ped_pending_d = 1'b0;
                end else if (tick_s) begin
                    secs_d = secs_q - 4'd1;
                end else begin
                    secs_d = secs_q;
                end
            end
            default: begin
                state_d       = ST_RED;
                secs_d        = RED_LOAD;
                ped_pending_d = 1'b0;
            end
        endcase
    end

    // Lamp and walk derive from the next state so they register alongside it.
    always_comb begin
        light_d = lamp_of(state_d);
        walk_d  = (state_d == ST_RED);
    end

    assign light     = light_q;
    assign secs_left = secs_q;
    assign ped_walk  = walk_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomized self-checking bench for traffic_light_fsm against an elapsed-tick reference model.
module tb_traffic_light_fsm;

    localparam int CLK_DIV = 4;
    localparam int RED_T   = 10;
    localparam int GRN_T   = 8;
    localparam int YEL_T   = 3;
    localparam int MIN_GRN = 3;

    logic       fast_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ped_req  = 1'b0;
    logic [0:2] light;
    logic [3:0] secs_left;
    logic       ped_walk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase index (0 red, 1 green, 2 yellow), ticks elapsed in phase.
    int m_phase   = 0;
    int m_elapsed = 0;
    int m_pcnt    = 0;
    bit m_pending = 1'b0;

    traffic_light_fsm #(.CLK_DIV(CLK_DIV)) dut (
        .fast_clk  (fast_clk),
        .rst_n     (rst_n),
        .ped_req   (ped_req),
        .light     (light),
        .secs_left (secs_left),
        .ped_walk  (ped_walk)
    );

    always #5 fast_clk = ~fast_clk;

    function automatic int dur(input int ph);
        case (ph)
            0:       return RED_T;
            1:       return GRN_T;
            default: return YEL_T;
        endcase
    endfunction

    function automatic logic [2:0] lamp(input int ph);
        case (ph)
            0:       return 3'b100;
            1:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rn, input bit req);
        bit tick_now;
        bit old_pending;
        bit done;
        if (!rn) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_pcnt    = 0;
            m_pending = 1'b0;
        end else begin
            tick_now    = (m_pcnt == CLK_DIV - 1);
            old_pending = m_pending;
            done        = 1'b0;
            m_pcnt      = (m_pcnt + 1) % CLK_DIV;
            if (req && m_phase != 0) m_pending = 1'b1;
            if (tick_now) begin
                m_elapsed++;
                if (m_elapsed == dur(m_phase)) done = 1'b1;
                if (m_phase == 1 && old_pending && m_elapsed >= MIN_GRN) done = 1'b1;
            end
            if (done) begin
                m_phase   = (m_phase + 1) % 3;
                m_elapsed = 0;
                if (m_phase == 0) m_pending = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit rn, input bit req);
        rst_n   = rn;
        ped_req = req;
        @(posedge fast_clk);
        model_edge(rn, req);
        #1;
        check("light", 32'(light), 32'(lamp(m_phase)));
        check("secs_left", 32'(secs_left), 32'(dur(m_phase) - 1 - m_elapsed));
        check("ped_walk", 32'(ped_walk), 32'(m_phase == 0));
        check("onehot", 32'($onehot(light)), 32'd1);
    endtask

    // Step until the DUT shows the given lamp; mode 0 idle, 1 held request,
    // 2 single pulse on the 5th cycle, 3 random pulses.
    task automatic run_until(input logic [2:0] code, input int mode, output int n);
        bit req;
        int k;
        n = 0;
        while (light !== code && n < 500) begin
            k = n + 1;
            case (mode)
                1:       req = 1'b1;
                2:       req = (k == 5);
                3:       req = ($urandom_range(0, 2) == 0);
                default: req = 1'b0;
            endcase
            cycle(1'b1, req);
            n = k;
        end
        if (light !== code) check("wait_timeout", 32'(light), 32'(code));
    endtask

    initial begin
        int n;
        int len;
        logic [2:0] prev;
        int runs[$];

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

        // Free run: measure completed phase lengths in cycles.
        prev = light;
        len  = 1;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b0);
            if (light !== prev) begin
                runs.push_back(len);
                len  = 1;
                prev = light;
            end else begin
                len++;
            end
        end
        check("run_green",  (runs.size() > 1) ? 32'(runs[1]) : 32'hFFFF_FFFF, 32'd32);
        check("run_yellow", (runs.size() > 2) ? 32'(runs[2]) : 32'hFFFF_FFFF, 32'd12);
        check("run_red",    (runs.size() > 3) ? 32'(runs[3]) : 32'hFFFF_FFFF, 32'd40);
        check("run_green2", (runs.size() > 4) ? 32'(runs[4]) : 32'hFFFF_FFFF, 32'd32);

        // Single ped pulse after the first green tick shortens green to 3 ticks.
        cycle(1'b0, 1'b0);
        run_until(3'b010, 0, n);
        run_until(3'b001, 2, n);
        check("green_ped_len", 32'(n), 32'd12);
        run_until(3'b100, 0, n);
        check("yellow_len", 32'(n), 32'd12);

        // Requests only during red are ignored; green runs the full 8 ticks.
        run_until(3'b010, 3, n);
        check("red_len", 32'(n), 32'd40);
        run_until(3'b001, 0, n);
        check("green_full_len", 32'(n), 32'd32);

        // One-cycle reset in the middle of yellow.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("mid_reset_light", 32'(light), 32'd4);
        check("mid_reset_secs", 32'(secs_left), 32'd9);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        check("restart_tick_secs", 32'(secs_left), 32'd8);

        // Request held high: every green lasts exactly 3 ticks.
        for (int r = 0; r < 2; r++) begin
            run_until(3'b010, 1, n);
            run_until(3'b001, 1, n);
            check("green_held_len", 32'(n), 32'd12);
        end

        // Random requests with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 399) != 0), ($urandom_range(0, 11) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
